// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state type and default widths for seq_gen (GAP state exists only with SEQ_GEN_GAP_EN).
package seq_gen_pkg;
  localparam int DEF_PAT_W = 16;
  localparam int DEF_LEN_W = $clog2(DEF_PAT_W) + 1;
  localparam int DEF_REP_W = 4;
`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
endpackage

// File: rtl/seq_shreg.sv
// seq_shreg: MSB-aligned pattern register that shifts left and presents its MSB as the serial bit.
module seq_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic         reload,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         msb
);
  logic [W-1:0] base_q, sh_q;
  assign msb = sh_q[W-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      sh_q   <= '0;
    end else begin
      if (load) base_q <= d;
      sh_q <= load ? d : reload ? base_q : clear ? '0 : shift ? sh_q << 1 : sh_q;
    end
  end
endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial MSB-first pattern generator with repeat count; SEQ_GEN_GAP_EN inserts one idle bit between passes.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W) + 1,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);
  state_t state_q, state_d;
  logic [LEN_W-1:0] bit_q, bit_d, len_q, len_c;
  logic [REP_W-1:0] pass_q, pass_d, reps_q;
  logic [PAT_W-1:0] aligned;
  logic accept, done_d, sh_load, sh_shift, sh_reload, sh_clear;
  assign len_c   = len > LEN_W'(PAT_W) ? LEN_W'(PAT_W) : len;
  assign accept  = load_valid && load_ready;
  // Left-align so bit len-1 sits in the MSB; bits above len-1 fall off.
  assign aligned = pat << (LEN_W'(PAT_W) - len_c);
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_reload = 1'b0;
    sh_clear  = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        done_d  = len_c == '0;
        state_d = len_c == '0 ? IDLE : SHIFT;
        bit_d   = len_c - LEN_W'(1);
        pass_d  = '0;
        sh_load = 1'b1;
      end
    end else if (abort) begin
      state_d  = IDLE;
      sh_clear = 1'b1;
    end else if (state_q == SHIFT) begin
      if (bit_q != '0) begin
        bit_d    = bit_q - LEN_W'(1);
        sh_shift = 1'b1;
      end else if (pass_q == reps_q) begin
        state_d  = IDLE;
        done_d   = 1'b1;
        sh_clear = 1'b1;
      end else begin
        pass_d = pass_q + REP_W'(1);
        bit_d  = len_q - LEN_W'(1);
`ifdef SEQ_GEN_GAP_EN
        state_d  = GAP;
        sh_clear = 1'b1;
`else
        sh_reload = 1'b1;
`endif
      end
    end
`ifdef SEQ_GEN_GAP_EN
    else begin
      state_d   = SHIFT;
      sh_reload = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      pass_q     <= '0;
      len_q      <= '0;
      reps_q     <= '0;
      load_ready <= 1'b1;
      a_valid    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      pass_q  <= pass_d;
      if (accept) begin
        len_q  <= len_c;
        reps_q <= reps;
      end
      load_ready <= state_d == IDLE;
      a_valid    <= state_d == SHIFT;
      busy       <= state_d != IDLE;
      done       <= done_d;
    end
  end
  seq_shreg #(.W(PAT_W)) u_shreg (
    .clk    (clk),
    .reset  (reset),
    .load   (sh_load),
    .shift  (sh_shift),
    .reload (sh_reload),
    .clear  (sh_clear),
    .d      (aligned),
    .msb    (a)
  );
endmodule

// File: doc/seq_gen.md
# seq_gen

Serial bit-pattern generator: accepts a parallel pattern through a valid/ready load, then drives it MSB-first on a one-bit serial line, one bit per clock, repeated a programmable number of times. It is the transmit-side counterpart of the `fsm` sequence detector. Its `a` output connects directly to the detector's `a` input, so detector pattern streams are produced in hardware rather than by timed testbench assignments.

## Interface
- PAT_W, 16, maximum pattern length in bits
- LEN_W, $clog2(PAT_W)+1, width of the length field (5 at default)
- REP_W, 4, width of the repeat field
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  load request
- load_ready  out  1  generator can accept a load (high only in IDLE)
- pat  in  PAT_W  pattern; bit len-1 is sent first, bit 0 last
- len  in  LEN_W  number of bits per repetition, 0..PAT_W
- reps  in  REP_W  extra repetitions; total passes = reps+1
- abort  in  1  stop immediately, no done pulse
- a  out  1  serial bit; 0 whenever a_valid is low
- a_valid  out  1  `a` carries a pattern bit this cycle
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse after the final bit of the final pass

## Operation
- States: IDLE, SHIFT, GAP (GAP exists only with SEQ_GEN_GAP_EN).
- Reset values: state=IDLE, load_ready=1, a=0, a_valid=0, busy=0, done=0; all internal registers cleared.
- Accept condition: load_valid && load_ready. On acceptance the block captures pat, len and reps.
- len > PAT_W is clamped to PAT_W.
- len == 0: the block stays in IDLE, emits no bits, and pulses done on the next cycle.
- SHIFT: each cycle, a = pat_q[bit_idx] and a_valid = 1. bit_idx counts down from len-1 to 0.
- At bit_idx == 0:
  - If the pass counter equals reps, go to IDLE and raise done.
  - Otherwise increment the pass counter, reload bit_idx = len-1, and go to SHIFT, or to GAP when the macro is defined.
- GAP: one cycle with a = 0 and a_valid = 0, then back to SHIFT.
- abort (any state except IDLE): state goes to IDLE on the next edge. No done pulse. The output goes quiet as in IDLE.
- abort in IDLE is ignored.
- abort and an accepted load in the same cycle: abort has no effect, and the load proceeds.
- reset mid-operation overrides everything; a pending done pulse is lost.
- load_valid while busy is ignored. No queuing; the source must hold load_valid until load_ready is high.
- Counter widths:
  - bit_idx is LEN_W bits.
  - The pass counter is REP_W bits and never wraps, because it is compared against reps before incrementing.

## Timing
- All outputs are registered.
- The first bit appears on `a` in the cycle after acceptance.
- done is high in the cycle after the last bit. In that cycle the state is IDLE and load_ready=1, so a new load can be accepted in the same cycle as done.
- Back-to-back loads therefore leave exactly one idle cycle between streams.
- Accept-to-done latency:
  - Without gap: (reps+1)*len + 1 cycles.
  - With SEQ_GEN_GAP_EN: (reps+1)*len + reps + 1 cycles.
- busy is high from the cycle after acceptance through the last bit cycle. It is low in the done cycle.

## Configuration
- SEQ_GEN_GAP_EN defined:
  - The GAP state is compiled in.
  - One a_valid=0 zero bit is inserted between consecutive passes.
  - No gap is inserted after the final pass.
- Not defined:
  - Passes are sent back-to-back with no idle bits.
  - The state encoding contains only IDLE and SHIFT.

## Structure
- Package seq_gen_pkg holds:
  - the state enum (IDLE, SHIFT, GAP)
  - the default PAT_W, LEN_W and REP_W constants
- One sub-module, seq_shreg:
  - a PAT_W-bit load/shift-left register that presents its selected MSB as the serial bit
  - the top level keeps the FSM and both counters

## Test plan
- Detector pattern: pat=16'h0137, len=10, reps=0 → a = 0,1,0,0,1,1,0,1,1,1 on cycles 1–10 after accept, a_valid high for those 10 cycles, done on cycle 11.
- Repeat without gap: pat=16'h0005, len=3, reps=2 → a = 101 101 101 on cycles 1–9, done on cycle 10.
- Repeat with SEQ_GEN_GAP_EN: same stimulus → a = 101,0,101,0,101 with a_valid=0 on cycles 4 and 8, done on cycle 12.
- Edge lengths:
  - len=0 → no a_valid, done on cycle 1.
  - len=16 with pat=16'h8001 → 1, fourteen 0s, 1.
  - len=20 is clamped to 16.
- Abort and reset:
  - abort on cycle 4 of a 10-bit stream → a_valid drops on cycle 5, done is never asserted, load_ready=1 on cycle 5.
  - reset asserted mid-stream → all outputs at reset values on the next cycle.
- Back-to-back loads: load_valid held high with a second pattern → second load is accepted in the done cycle of the first, and its first bit follows one cycle later; a load_valid pulse while busy is dropped.
